// File: rtl/intr_priority_ctrl_if.sv
// Interrupt request / acknowledge bundle between the interrupt sources, the CPU and intr_priority_ctrl.
// master: the environment (sources and CPU); slave: the controller.
interface intr_priority_ctrl_if;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       IACK;
    logic       INT;
    logic [1:0] priority_select;
    logic [3:0] pending;

    modport master (
        output irq,
        output mask,
        output IACK,
        input  INT,
        input  priority_select,
        input  pending
    );

    modport slave (
        input  irq,
        input  mask,
        input  IACK,
        output INT,
        output priority_select,
        output pending
    );
endinterface

// File: rtl/intr_priority_ctrl.sv
// Four-source fixed-priority interrupt controller with an INT/IACK handshake (bit 3 highest).
// Define INTC_IRQ_EDGE_EN for edge-triggered capture; the default build is level-sensitive.
module intr_priority_ctrl (
    input logic                 clk,
    input logic                 rst,
    intr_priority_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        ACKED  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       int_q, int_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] eligible;
    logic [1:0] winner;

`ifdef INTC_IRQ_EDGE_EN
    logic [3:0] irq_q;
    logic [3:0] pending_clr;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        pending_clr = '0;
        if (state_q == ASSERT && bus.IACK) begin
            pending_clr[sel_q] = 1'b1;
        end
        // The set term is applied after the clear, so a fresh edge in the ack cycle re-pends.
        pending_d = (pending_q & ~pending_clr) | (bus.irq & ~irq_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= '0;
        end else begin
            irq_q <= bus.irq;
        end
    end
`else
    always_comb begin
        pending_d = bus.irq;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign eligible = pending_q & ~bus.mask;

    // Ascending scan: the highest set index is the last to write.
    always_comb begin
        winner = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eligible[i]) begin
                winner = i[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        int_d   = int_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    state_d = ASSERT;
                    sel_d   = winner;
                    int_d   = 1'b1;
                end
            end
            ASSERT: begin
                if (bus.IACK) begin
                    state_d = ACKED;
                    int_d   = 1'b0;
                end
            end
            ACKED: begin
                if (!bus.IACK) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            int_q   <= int_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.INT             = int_q;
    assign bus.priority_select = sel_q;
    assign bus.pending         = pending_q;

endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Self-checking bench for intr_priority_ctrl: vector table, hand-written reset cases, random run vs model.
// Expectations follow INTC_IRQ_EDGE_EN the same way the design does.
module tb_intr_priority_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    intr_priority_ctrl_if bus ();

    intr_priority_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] mask;
        logic       iack;
        logic       exp_int;
        logic [1:0] exp_sel;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vecs[$];

    // Reference model: one interrupt "phase" counter plus the pending set.
    int         m_phase;     // 0 waiting for a request, 1 waiting for ack, 2 waiting for ack release
    logic       m_int;
    logic [1:0] m_sel;
    logic [3:0] m_pend;
    logic [3:0] m_prev_irq;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] irq, input logic [3:0] mask, input logic iack,
                           input logic e_int, input logic [1:0] e_sel, input logic [3:0] e_pend);
        vec_t v;
        v.irq = irq; v.mask = mask; v.iack = iack;
        v.exp_int = e_int; v.exp_sel = e_sel; v.exp_pend = e_pend;
        vecs.push_back(v);
    endtask

    task automatic model_reset();
        m_phase = 0; m_int = 1'b0; m_sel = 2'd0; m_pend = 4'd0; m_prev_irq = 4'd0;
    endtask

    // Advance the model by one clock edge given the inputs present before that edge.
    task automatic model_step(input logic [3:0] irq, input logic [3:0] mask, input logic iack);
        logic [3:0] new_pend;
        logic [3:0] avail;
`ifdef INTC_IRQ_EDGE_EN
        new_pend = m_pend;
        if (m_phase == 1 && iack) new_pend = new_pend & ~(4'b0001 << m_sel);
        new_pend = new_pend | (irq & ~m_prev_irq);
`else
        new_pend = irq;
`endif
        m_prev_irq = irq;
        avail = m_pend & ~mask;
        if (m_phase == 0) begin
            for (int b = 3; b >= 0; b--) begin
                if (avail[b] && m_phase == 0) begin
                    m_sel = 2'(b);
                    m_int = 1'b1;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (iack) begin
                m_int = 1'b0;
                m_phase = 2;
            end
        end else begin
            if (!iack) m_phase = 0;
        end
        m_pend = new_pend;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.irq = 4'd0; bus.mask = 4'd0; bus.IACK = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_outputs(input string tag, input logic e_int, input logic [1:0] e_sel,
                                 input logic [3:0] e_pend);
        check({tag, " INT"}, {3'b000, bus.INT}, {3'b000, e_int});
        check({tag, " sel"}, {2'b00, bus.priority_select}, {2'b00, e_sel});
        check({tag, " pending"}, bus.pending, e_pend);
    endtask

    task automatic fill_table();
`ifdef INTC_IRQ_EDGE_EN
        // single request on source 1
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        // sources 0 and 2 together
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0101);
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0101);
        add_vec(4'b0101, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0001);
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0001);
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001);
        // source 3 arrives during service of source 0: no preemption
        add_vec(4'b1101, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1001);
        add_vec(4'b1101, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1000);
        add_vec(4'b1101, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b1000);
        add_vec(4'b1101, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add_vec(4'b1101, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        add_vec(4'b1101, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000);
        // masked source stays pending without INT
        add_vec(4'b0000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b0000);
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000);
        // new edge on source 2 in the same cycle as its acknowledge
        add_vec(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0100);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000);
`else
        // held request on source 1 is re-selected after the handshake
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0010);
        add_vec(4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 4'b0010);
        add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        // sources 0 and 2 together
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b0, 2'd1, 4'b0101);
        add_vec(4'b0101, 4'b0000, 1'b0, 1'b1, 2'd2, 4'b0101);
        add_vec(4'b0001, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0001);
        add_vec(4'b0001, 4'b0000, 1'b0, 1'b0, 2'd2, 4'b0001);
        add_vec(4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001);
        // source 3 arrives during service of source 0: no preemption
        add_vec(4'b1001, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b1001);
        add_vec(4'b1000, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1000);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b1000);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000);
        // masked source stays pending without INT; IACK in IDLE ignored
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b1000, 1'b1, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b1000, 1'b0, 1'b0, 2'd3, 4'b1000);
        add_vec(4'b1000, 4'b0000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add_vec(4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000);
        add_vec(4'b0000, 4'b0000, 1'b0, 1'b0, 2'd3, 4'b0000);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.irq = 4'd0; bus.mask = 4'd0; bus.IACK = 1'b0;

        // Reset with all lines high, then release
        @(negedge clk);
        bus.irq = 4'b1111;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("in_reset", 1'b0, 2'd0, 4'b0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("rel_edge1", 1'b0, 2'd0, 4'b1111);
        @(posedge clk);
        #1;
        check_outputs("rel_edge2", 1'b1, 2'd3, 4'b1111);

        // Vector table
        do_reset();
        fill_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.irq = vecs[i].irq;
            bus.mask = vecs[i].mask;
            bus.IACK = vecs[i].iack;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_int, vecs[i].exp_sel, vecs[i].exp_pend);
        end

        // Asynchronous reset while in ACKED
        do_reset();
        @(negedge clk);
        bus.irq = 4'b0101;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("pre_ack", 1'b1, 2'd2, 4'b0101);
        @(negedge clk);
        bus.IACK = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_outputs("rst_in_acked", 1'b0, 2'd0, 4'b0000);

        // Randomized run against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r_irq;
            logic [3:0] r_mask;
            logic       r_iack;
            @(negedge clk);
            r_irq = bus.irq;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
            end
            r_mask = bus.mask;
            if ($urandom_range(0, 9) == 0) r_mask = 4'($urandom_range(0, 15));
            if (m_phase == 1)      r_iack = ($urandom_range(0, 2) == 0);
            else if (m_phase == 2) r_iack = ($urandom_range(0, 2) != 0);
            else                   r_iack = ($urandom_range(0, 7) == 0);
            bus.irq = r_irq;
            bus.mask = r_mask;
            bus.IACK = r_iack;
            model_step(r_irq, r_mask, r_iack);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rnd%0d", c), m_int, m_sel, m_pend);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
